// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter and display blocks.
package counter_pkg;

  localparam int COUNTER_WIDTH   = 4;
  localparam int COUNTER_MODULUS = 16;

  // Binary-reflected Gray code for values up to 16 bits.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE clocks.
module counter_prescaler #(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_p;
  logic          w_tick;

  assign w_tick = (r_p == PW'(PRESCALE - 1));
  assign tick   = w_tick;

  // Phase counter: runs 0..PRESCALE-1 and restarts at phase 0 on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p <= '0;
    end else if (w_tick) begin
      r_p <= '0;
    end else begin
      r_p <= r_p + 1'b1;
    end
  end

endmodule

// File: rtl/counter.sv
// Free-running modulo counter with terminal-count pulse, Gray-coded copy
// of the count and a saturating wrap counter.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = COUNTER_WIDTH,
  parameter int MODULUS     = COUNTER_MODULUS,
  parameter int PRESCALE    = 1,
  parameter int DOWN        = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] a,
  output logic             tc,
  output logic [WIDTH-1:0] a_gray,
  output logic [7:0]       wraps
);

  // Elaboration-time parameter legality.
  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("counter: WIDTH must be 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("counter: MODULUS must be 2..2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
      $error("counter: PRESCALE must be 1..65535");
    end
    if (DOWN != 0 && DOWN != 1) begin : g_bad_down
      $error("counter: DOWN must be 0 or 1");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
      $error("counter: RESET_VALUE must be below MODULUS");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TERM = (DOWN != 0) ? '0 : LAST;
  localparam logic [WIDTH-1:0] RV   = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] r_a;
  logic             r_tc;
  logic [7:0]       r_wraps;
  logic             w_tick;
  logic [WIDTH-1:0] w_next;
  logic             w_at_term;

  // PRESCALE=1 steps every clock, so no phase register is built.
  generate
    if (PRESCALE > 1) begin : g_prescaler
      counter_prescaler #(
        .PRESCALE (PRESCALE)
      ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
      );
    end else begin : g_no_prescaler
      assign w_tick = 1'b1;
    end
  endgenerate

  assign w_at_term = (r_a == TERM);

  // Next count value with an explicit wrap so non-power-of-two moduli work.
  always_comb begin
    w_next = r_a;
    if (DOWN == 0) begin
      w_next = (r_a == LAST) ? '0 : r_a + 1'b1;
    end else begin
      w_next = (r_a == '0) ? LAST : r_a - 1'b1;
    end
  end

  // Count, terminal pulse and saturating wrap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= RV;
      r_tc    <= 1'b0;
      r_wraps <= '0;
    end else begin
      r_tc <= w_tick && w_at_term;
      if (w_tick) begin
        r_a <= w_next;
      end
      if (w_tick && w_at_term && r_wraps != 8'hFF) begin
        r_wraps <= r_wraps + 8'd1;
      end
    end
  end

  assign a      = r_a;
  assign tc     = r_tc;
  assign wraps  = r_wraps;
  assign a_gray = WIDTH'(bin2gray(16'(r_a)));

endmodule

// File: tb/tb_counter.sv
// Bench for counter: four configurations share one clock and reset and are
// compared every cycle against a closed-form model driven by the number of
// clock edges seen since reset release.
module tb_counter;

  logic clk;
  logic rst;

  // Configuration table: 0 default, 1 modulo 10, 2 down from 3, 3 prescale 4.
  int cfg_m [4] = '{16, 10, 16, 16};
  int cfg_ps[4] = '{1, 1, 1, 4};
  int cfg_dn[4] = '{0, 0, 1, 0};
  int cfg_rv[4] = '{0, 0, 3, 0};
  string cfg_name[4] = '{"def", "m10", "dn3", "ps4"};

  logic [3:0] a0, a1, a2, a3;
  logic [3:0] g0, g1, g2, g3;
  logic       tc0, tc1, tc2, tc3;
  logic [7:0] w0, w1, w2, w3;

  int checks;
  int failures;
  int edges;

  counter u_def (
    .clk(clk), .rst(rst), .a(a0), .tc(tc0), .a_gray(g0), .wraps(w0)
  );
  counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk(clk), .rst(rst), .a(a1), .tc(tc1), .a_gray(g1), .wraps(w1)
  );
  counter #(.WIDTH(4), .MODULUS(16), .DOWN(1), .RESET_VALUE(3)) u_dn3 (
    .clk(clk), .rst(rst), .a(a2), .tc(tc2), .a_gray(g2), .wraps(w2)
  );
  counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(4)) u_ps4 (
    .clk(clk), .rst(rst), .a(a3), .tc(tc3), .a_gray(g3), .wraps(w3)
  );

  // Clock block: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since release; cleared the moment reset asserts.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of wraps after s steps.
  function automatic int wrap_count(input int s, input int m, input int dn,
                                    input int rv);
    if (dn == 0) return (rv + s) / m;
    if (s >= rv + 1) return (s - rv - 1) / m + 1;
    return 0;
  endfunction

  task automatic check_cfg(input int i, input logic [3:0] a,
                           input logic tc, input logic [3:0] g,
                           input logic [7:0] w);
    int s, ea, etc, ew;
    logic [3:0] ea4;
    s = edges / cfg_ps[i];
    if (cfg_dn[i] == 0) ea = (cfg_rv[i] + s) % cfg_m[i];
    else                ea = ((cfg_rv[i] - s) % cfg_m[i] + cfg_m[i]) % cfg_m[i];
    ew  = wrap_count(s, cfg_m[i], cfg_dn[i], cfg_rv[i]);
    etc = (edges > 0 && edges % cfg_ps[i] == 0 && s > 0 &&
           ew != wrap_count(s - 1, cfg_m[i], cfg_dn[i], cfg_rv[i])) ? 1 : 0;
    if (ew > 255) ew = 255;
    ea4 = 4'(ea);
    check_val({cfg_name[i], ".a"},      32'(a),  32'(ea));
    check_val({cfg_name[i], ".tc"},     32'(tc), 32'(etc));
    check_val({cfg_name[i], ".a_gray"}, 32'(g),  32'(ea4 ^ (ea4 >> 1)));
    check_val({cfg_name[i], ".wraps"},  32'(w),  32'(ew));
  endtask

  task automatic check_all();
    check_cfg(0, a0, tc0, g0, w0);
    check_cfg(1, a1, tc1, g1, w1);
    check_cfg(2, a2, tc2, g2, w2);
    check_cfg(3, a3, tc3, g3, w3);
  endtask

  // Driver: run n cycles, checking every output on each falling edge.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  // Driver: assert reset between edges, check at once, then release
  // away from a rising edge.
  task automatic pulse_reset(input int hold_cycles);
    @(posedge clk);
    #($urandom_range(1, 4));
    rst = 1'b0;
    #1;
    check_all();
    repeat (hold_cycles) @(posedge clk);
    @(negedge clk);
    #($urandom_range(0, 3));
    rst = 1'b1;
  endtask

  initial begin
    int found;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;

    // Reset state, sampled well inside the 100 ns reset window.
    #50;
    check_all();
    check_val("def.reset_a", 32'(a0), 32'd0);
    check_val("dn3.reset_a", 32'(a2), 32'd3);

    // Release at 100 ns (a falling edge) and watch the first wraps.
    @(negedge clk);
    while ($time < 100) @(negedge clk);
    rst = 1'b1;
    run_cycles(40);

    // Reset while the default counter shows 9; it must clear before the
    // next rising edge.
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      check_all();
      if (a0 == 4'd9) found = 1;
    end
    check_val("wait_a9", 32'(found), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("async.a",     32'(a0), 32'd0);
    check_val("async.tc",    32'(tc0), 32'd0);
    check_val("async.wraps", 32'(w0), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    run_cycles($urandom_range(20, 60));

    // Random run lengths with random mid-cycle reset pulses.
    for (int k = 0; k < 6; k++) begin
      pulse_reset($urandom_range(0, 2));
      run_cycles($urandom_range(5, 200));
    end

    // Long run: wrap counters reach 255 and hold while counting continues.
    pulse_reset(1);
    run_cycles(300 * 16 + $urandom_range(10, 40));
    check_val("def.sat", 32'(w0), 32'd255);
    check_val("m10.sat", 32'(w1), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
